// File: rtl/binary_to_stochastic_if.sv
// rtl/binary_to_stochastic_if.sv - control and stream bundle for the binary-to-stochastic encoder
interface binary_to_stochastic_if #(
   parameter int WIDTH = 4
);
   logic                  start;
   logic [WIDTH-1:0]      bnum;
   logic                  sc_ready;
   logic                  sc_bit;
   logic                  sc_valid;
   logic [2**WIDTH-1:0]   sc_word;
   logic                  busy;
   logic                  done;

   // Requester side: issues conversions and consumes the stream.
   modport master (
      output start,
      output bnum,
      output sc_ready,
      input  sc_bit,
      input  sc_valid,
      input  sc_word,
      input  busy,
      input  done
   );

   // Encoder side.
   modport slave (
      input  start,
      input  bnum,
      input  sc_ready,
      output sc_bit,
      output sc_valid,
      output sc_word,
      output busy,
      output done
   );
endinterface

// File: rtl/binary_to_stochastic.sv
// rtl/binary_to_stochastic.sv - encodes an unsigned operand into a 2^WIDTH-bit stochastic stream
module binary_to_stochastic #(
   parameter int WIDTH = 4,
   parameter int SEED  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   binary_to_stochastic_if.slave bus
);
   localparam int              LEN     = 2**WIDTH;
   localparam logic [WIDTH-1:0] IDX_MAX = '1;

   // An all-zero seed would lock the LFSR, so it is promoted to 1.
   localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
   localparam logic [WIDTH-1:0] SEED_EFF = (SEED_W == '0) ? WIDTH'(1) : SEED_W;

   // Tap masks of the maximal-length polynomials, one per supported width.
   localparam logic [7:0] TAPS =
      (WIDTH == 3) ? 8'b0000_0110 :
      (WIDTH == 4) ? 8'b0000_1100 :
      (WIDTH == 5) ? 8'b0001_0100 :
      (WIDTH == 6) ? 8'b0011_0000 :
      (WIDTH == 7) ? 8'b0110_0000 :
                     8'b1011_1000;
   localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   op_q;
   logic [WIDTH-1:0]   idx;
   logic [WIDTH-1:0]   lfsr;
   logic [LEN-1:0]     word_q;
   logic               valid_q;
   logic               busy_q;
   logic               done_q;

   logic               feedback;
   logic [WIDTH-1:0]   lfsr_next;
   logic [WIDTH-1:0]   rnd;
   logic               sc_bit;
   logic               xfer;

   // Fibonacci step: shift left, XOR of the tapped bits enters at bit 0.
   always_comb begin
      feedback  = ^(lfsr & TAP_MASK);
      lfsr_next = {lfsr[WIDTH-2:0], feedback};
   end

   // Index 0 uses the zero value the LFSR can never produce, so the
   // comparand sequence covers every value 0..2^WIDTH-1 exactly once.
   always_comb begin
      rnd    = (idx == '0) ? '0 : lfsr;
      sc_bit = valid_q & (rnd < op_q);
      xfer   = valid_q & bus.sc_ready;
   end

   // Control FSM with registered status outputs and stream capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         op_q    <= '0;
         idx     <= '0;
         lfsr    <= SEED_EFF;
         word_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  op_q    <= bus.bnum;
                  idx     <= '0;
                  word_q  <= '0;
                  lfsr    <= SEED_EFF;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (xfer) begin
                  word_q[idx] <= sc_bit;
                  // The seed is consumed at index 1, so hold it across index 0.
                  if (idx != '0) begin
                     lfsr <= lfsr_next;
                  end
                  if (idx == IDX_MAX) begin
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                     state   <= ST_DONE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.sc_bit   = sc_bit;
   assign bus.sc_valid = valid_q;
   assign bus.sc_word  = word_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

   // done is a single-cycle pulse.
   a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
      done_q |=> !done_q);

   // A valid stream bit only exists while the encoder is busy.
   a_valid_busy: assert property (@(posedge clk) disable iff (!rst_n)
      valid_q |-> busy_q);

   // A stalled bit stays presented unchanged.
   a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (valid_q && !bus.sc_ready) |=> (valid_q && $stable(sc_bit)));
endmodule

// File: tb/tb_binary_to_stochastic.sv
// tb/tb_binary_to_stochastic.sv - directed self-checking bench for binary_to_stochastic
module tb_binary_to_stochastic;
   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   binary_to_stochastic_if #(.WIDTH(4)) i4 ();
   binary_to_stochastic_if #(.WIDTH(3)) i3 ();
   binary_to_stochastic_if #(.WIDTH(8)) i8 ();

   binary_to_stochastic #(.WIDTH(4), .SEED(1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
   binary_to_stochastic #(.WIDTH(3), .SEED(1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(i3.slave));
   binary_to_stochastic #(.WIDTH(8), .SEED(1)) dut8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One WIDTH=4 conversion; sampling and driving both happen at negedges.
   task automatic run4(input logic [3:0] b, input bit rnd_ready, input bit inject,
                       output logic [15:0] word, output int lat, output int xfers,
                       output bit first_ok, output bit hold_ok, output bit timed_out);
      bit   prev_stall;
      logic prev_bit;
      hold_ok    = 1'b1;
      first_ok   = 1'b0;
      xfers      = 0;
      lat        = 0;
      timed_out  = 1'b1;
      prev_stall = 1'b0;
      prev_bit   = 1'b0;
      @(negedge clk);
      i4.start = 1'b1;
      i4.bnum  = b;
      for (int n = 1; n < 400; n++) begin
         @(negedge clk);
         if (n == 1) begin
            first_ok = i4.sc_valid && i4.busy;
            i4.bnum  = ~b;
         end
         if (prev_stall && (i4.sc_bit !== prev_bit || i4.sc_valid !== 1'b1)) hold_ok = 1'b0;
         if (i4.done) begin
            lat       = n;
            timed_out = 1'b0;
            break;
         end
         i4.start    = (inject && n == 5);
         if (inject && n == 5) i4.bnum = 4'd3;
         i4.sc_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (i4.sc_valid && i4.sc_ready) xfers++;
         prev_stall = i4.sc_valid && !i4.sc_ready;
         prev_bit   = i4.sc_bit;
      end
      word        = i4.sc_word;
      i4.start    = 1'b0;
      i4.sc_ready = 1'b1;
   endtask

   task automatic run3(input logic [2:0] b, output logic [7:0] word, output bit timed_out);
      @(negedge clk);
      i3.start  = 1'b1;
      i3.bnum   = b;
      @(negedge clk);
      i3.start  = 1'b0;
      timed_out = 1'b1;
      for (int n = 0; n < 40; n++) begin
         if (i3.done) begin
            timed_out = 1'b0;
            break;
         end
         @(negedge clk);
      end
      word = i3.sc_word;
      @(negedge clk);
   endtask

   task automatic run8(input logic [7:0] b, output logic [255:0] word, output bit timed_out);
      @(negedge clk);
      i8.start  = 1'b1;
      i8.bnum   = b;
      @(negedge clk);
      i8.start  = 1'b0;
      timed_out = 1'b1;
      for (int n = 0; n < 300; n++) begin
         if (i8.done) begin
            timed_out = 1'b0;
            break;
         end
         @(negedge clk);
      end
      word = i8.sc_word;
      @(negedge clk);
   endtask

   initial begin
      logic [15:0]  w;
      logic [7:0]   w3;
      logic [255:0] w8;
      int           lat;
      int           xf;
      bit           f_ok;
      bit           h_ok;
      bit           to;
      bit           saw_done;

      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      i4.start = 1'b0; i4.bnum = '0; i4.sc_ready = 1'b1;
      i3.start = 1'b0; i3.bnum = '0; i3.sc_ready = 1'b1;
      i8.start = 1'b0; i8.bnum = '0; i8.sc_ready = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_valid", i4.sc_valid, 0);
      check("rst_busy",  i4.busy,     0);
      check("rst_done",  i4.done,     0);
      check("rst_bit",   i4.sc_bit,   0);
      check("rst_word4", i4.sc_word,  0);
      check("rst_word3", i3.sc_word,  0);
      check("rst_word8", i8.sc_word,  0);
      rst_n = 1'b1;
      @(negedge clk);

      // bnum=5: ones at idx 0,1,2,3,5 (rnd 0,1,2,4,3).
      run4(4'd5, 1'b0, 1'b0, w, lat, xf, f_ok, h_ok, to);
      check("b5_timeout", to, 0);
      check("b5_first_valid", f_ok, 1);
      check("b5_word", w, 16'h002F);
      check("b5_pop", $countones(w), 5);
      check("b5_latency", lat, 17);
      check("b5_xfers", xf, 16);
      @(negedge clk);
      check("b5_done_pulse", i4.done, 0);
      check("b5_idle_busy", i4.busy, 0);
      check("b5_word_held", i4.sc_word, 16'h002F);

      run4(4'd0, 1'b0, 1'b0, w, lat, xf, f_ok, h_ok, to);
      @(negedge clk);
      check("b0_timeout", to, 0);
      check("b0_word", w, 16'h0000);

      // bnum=15: only rnd=15 (idx 12) yields a zero.
      run4(4'd15, 1'b0, 1'b0, w, lat, xf, f_ok, h_ok, to);
      @(negedge clk);
      check("b15_timeout", to, 0);
      check("b15_word", w, 16'hEFFF);
      check("b15_pop", $countones(w), 15);
      check("b15_bit0", w[0], 1);

      run4(4'd9, 1'b0, 1'b0, w, lat, xf, f_ok, h_ok, to);
      @(negedge clk);
      check("b9_timeout", to, 0);
      check("b9_word", w, 16'h8A6F);

      run4(4'd9, 1'b1, 1'b0, w, lat, xf, f_ok, h_ok, to);
      @(negedge clk);
      check("b9s_timeout", to, 0);
      check("b9s_word", w, 16'h8A6F);
      check("b9s_hold", h_ok, 1);
      check("b9s_xfers", xf, 16);

      // bnum=12 with a bnum=3 start injected mid-stream.
      run4(4'd12, 1'b0, 1'b1, w, lat, xf, f_ok, h_ok, to);
      @(negedge clk);
      check("b12_timeout", to, 0);
      check("b12_word", w, 16'h8F7F);
      check("b12_pop", $countones(w), 12);
      check("b12_latency", lat, 17);

      // Reset while idx=7.
      @(negedge clk);
      i4.start = 1'b1;
      i4.bnum  = 4'd12;
      @(negedge clk);
      i4.start = 1'b0;
      repeat (7) @(negedge clk);
      check("pre_rst_valid", i4.sc_valid, 1);
      rst_n = 1'b0;
      #1;
      check("arst_valid", i4.sc_valid, 0);
      check("arst_busy",  i4.busy,     0);
      check("arst_done",  i4.done,     0);
      check("arst_bit",   i4.sc_bit,   0);
      check("arst_word",  i4.sc_word,  0);
      saw_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (i4.done) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (i4.done || i4.busy) saw_done = 1'b1;
      end
      check("arst_no_done", saw_done, 0);

      run4(4'd6, 1'b0, 1'b0, w, lat, xf, f_ok, h_ok, to);
      @(negedge clk);
      check("b6_timeout", to, 0);
      check("b6_word", w, 16'h022F);
      check("b6_pop", $countones(w), 6);

      for (int b = 0; b < 8; b++) begin
         run3(3'(b), w3, to);
         check("w3_timeout", to, 0);
         check($sformatf("w3_pop_%0d", b), $countones(w3), b);
      end

      for (int b = 0; b < 256; b++) begin
         run8(8'(b), w8, to);
         check("w8_timeout", to, 0);
         check($sformatf("w8_pop_%0d", b), $countones(w8), b);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/binary_to_stochastic.md
BINARY_TO_STOCHASTIC -- requirements
Module: binary_to_stochastic

Interface
REQ-001 Parameter WIDTH, default 4, binary operand width; legal range 3..8.
REQ-002 Parameter SEED, default 1, initial LFSR state; a value of 0 SHALL be replaced by 1.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to convert bnum; sampled only in IDLE.
REQ-006 bnum  input  WIDTH  unsigned binary value to encode (probability bnum/2^WIDTH).
REQ-007 sc_ready  input  1  downstream accepts the current stream bit when high.
REQ-008 sc_bit  output  1  current stochastic stream bit.
REQ-009 sc_valid  output  1  sc_bit is valid.
REQ-010 sc_word  output  2^WIDTH  packed stream; bit i = i-th emitted bit.
REQ-011 busy  output  1  high in RUN and DONE.
REQ-012 done  output  1  one-cycle pulse; sc_word complete.

Function
REQ-013 FSM states IDLE, RUN, DONE; encoding free.
REQ-014 IDLE->RUN on posedge with start=1: latch bnum into op_q, clear idx to 0, clear sc_word, load LFSR with SEED.
REQ-015 start while busy SHALL be ignored; bnum changes after acceptance SHALL have no effect.
REQ-016 In RUN, sc_valid=1 and sc_bit = (rnd < op_q), an unsigned WIDTH-bit compare, combinational from registered state.
REQ-017 rnd = 0 when idx=0; otherwise rnd = current LFSR state.
REQ-018 Transfer occurs on a posedge with sc_valid=1 and sc_ready=1: sc_word[idx] <= sc_bit; idx increments.
REQ-019 The LFSR SHALL advance only on transfers with idx>=1, so it holds SEED through the transfer at idx 0 and idx 1 uses SEED.
REQ-020 sc_ready=0 SHALL stall: sc_bit, idx and LFSR held; no bit lost or duplicated.
REQ-021 LFSR: Fibonacci, maximal length, shift left, feedback into bit 0, with these feedback polynomials:
  - WIDTH 3: x^3+x^2+1
  - WIDTH 4: x^4+x^3+1
  - WIDTH 5: x^5+x^3+1
  - WIDTH 6: x^6+x^5+1
  - WIDTH 7: x^7+x^6+1
  - WIDTH 8: x^8+x^6+x^5+x^4+1
REQ-022 Over idx 0..2^WIDTH-1, rnd takes every value 0..2^WIDTH-1 exactly once; the stream SHALL contain exactly op_q ones.
REQ-023 Transfer at idx=2^WIDTH-1 (wrap boundary) -> DONE; idx not wrapped into a new stream.
REQ-024 DONE lasts exactly one cycle: done=1, sc_valid=0, busy=1; then IDLE.
REQ-025 sc_word SHALL hold its value in IDLE until the next accepted start.
REQ-026 bnum=0 -> all-zero stream; bnum=2^WIDTH-1 -> exactly one zero, at the index where rnd=2^WIDTH-1.
REQ-027 Latency: start accepted at edge k -> sc_valid=1 from cycle k+1; with sc_ready held high, done at cycle k+1+2^WIDTH.

Reset
REQ-028 rst_n=0 asynchronously forces IDLE; outputs SHALL reset as follows:
  - sc_bit, sc_valid, busy, done = 0
  - sc_word = 0
  - idx = 0
  - LFSR = SEED
REQ-029 Reset mid-RUN SHALL abort the stream with no done pulse; first start after release behaves as from power-up.

Verification
REQ-030 WIDTH=4, bnum=5, sc_ready=1 -> 16 valid bits, popcount(sc_word)=5, done 17 cycles after start edge.
REQ-031 WIDTH=4, bnum=0 and bnum=15 -> sc_word=16'h0000, then exactly 15 ones with sc_bit=1 at idx 0.
REQ-032 Run bnum=9 with sc_ready toggled pseudo-randomly -> same sc_word as the sc_ready=1 run for bnum=9; valid bits hold while stalled.
REQ-033 start pulsed with bnum=3 mid-stream of a bnum=12 conversion -> ignored; popcount=12.
REQ-034 rst_n low at idx=7 -> outputs immediately per REQ-028; no done; a new start with bnum=6 yields popcount 6.
REQ-035 Sweep bnum 0..2^WIDTH-1 for WIDTH 3 and 8 -> popcount(sc_word)==bnum every case.
